// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the load/store unit and its byte-lane helper.
package dmem_lsu_pkg;

  localparam int DATA_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/dmem_lsu_byte_lane.sv
// Byte-lane helper: extracts one lane (zero-extended) from a word and
// builds the word with that lane replaced. The load path uses the extract
// result and the store path uses the merge result.
module byte_lane_unit
  import dmem_lsu_pkg::*;
(
  input  logic [LANE_W-1:0] lane,
  input  logic [DATA_W-1:0] word,
  input  logic [7:0]        wbyte,
  output logic [DATA_W-1:0] lane_data,
  output logic [DATA_W-1:0] merged
);

  // Select and replace the addressed little-endian lane.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // it unassigned and no latch is inferred.
    lane_data = '0;
    merged    = word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (lane == LANE_W'(i)) begin
        lane_data[7:0]  = word[8*i +: 8];
        merged[8*i +: 8] = wbyte;
      end
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and a word-only dmem. It passes word
// accesses straight through and adds zero-extended byte loads and two-cycle
// read-modify-write byte stores. Load data is returned registered, one cycle
// after the request is accepted.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              err_range,
  output logic [31:0]       mem_a,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  localparam logic [29:0] MEM_IDX_LIMIT = 30'(MEM_WORDS);

  lsu_state_t        state;
  lsu_state_t        state_next;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] lane_data;
  logic [DATA_W-1:0] merged;
  logic              accept;
  logic              in_range;
  logic              load_acc;
  logic              byte_store_acc;

  // The word index must fall inside dmem; byte offset bits never fault.
  assign in_range       = (req_addr[31:2] < MEM_IDX_LIMIT);
  assign accept         = req_valid & req_ready;
  assign load_acc       = accept & ~req_write;
  assign byte_store_acc = accept & req_write & req_byte & in_range;

  // Lane extract for byte loads and lane merge for byte stores, both taken
  // from the word dmem returns for the current request address.
  byte_lane_unit u_lane (
    .lane      (req_addr[LANE_W-1:0]),
    .word      (mem_rd),
    .wbyte     (req_wdata[7:0]),
    .lane_data (lane_data),
    .merged    (merged)
  );

  // State register; reset abandons any pending byte-store write.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: only an in-range byte store leaves IDLE, for exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (byte_store_acc) state_next = RMW_WR;
      RMW_WR:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: handshake and dmem drive; write enable is killed while in reset.
  always_comb begin
    req_ready = (state == IDLE) & reset;
    mem_a     = req_addr;
    mem_wd    = req_wdata;
    mem_we    = 1'b0;
    if (state == RMW_WR) begin
      mem_a  = addr_q;
      mem_wd = merge_q;
      mem_we = reset;
    end else begin
      mem_we = accept & req_write & ~req_byte & in_range;
    end
  end

  // Response, error pulse and byte-store merge registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      err_range  <= 1'b0;
      addr_q     <= '0;
      merge_q    <= '0;
    end else begin
      resp_valid <= load_acc;
      err_range  <= accept & ~in_range;
      if (load_acc) begin
        if (!in_range)     resp_rdata <= '0;
        else if (req_byte) resp_rdata <= lane_data;
        else               resp_rdata <= mem_rd;
      end
      if (byte_store_acc) begin
        addr_q  <= req_addr;
        merge_q <= merged;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: a behavioural word dmem, a reference memory model and a
// scoreboard of expected responses keyed by the cycle they are due.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        err_range;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  always #5 clk = ~clk;

  dmem_lsu #(.MEM_WORDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_byte   (req_byte),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .err_range  (err_range),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd)
  );

  // Word-only dmem: combinational read, write on posedge.
  logic [31:0] mem [64] = '{default: 32'h0};
  logic        bad_write = 1'b0;
  logic [29:0] mem_idx;
  assign mem_idx = mem_a[31:2];
  assign mem_rd  = (mem_idx < 30'd64) ? mem[mem_idx[5:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_idx < 30'd64) mem[mem_idx[5:0]] <= mem_wd;
      else                  bad_write <= 1'b1;
    end
  end

  typedef struct {
    int          due;
    logic        is_load;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_mem [64];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        rmw_pending = 1'b0;
  int          rmw_idx = 0;
  logic [31:0] rmw_word = '0;
  logic [31:0] rmw_addr = '0;

  // Every sampling point goes through here: checks the response expected this
  // cycle (or its absence) and the RMW write cycle of a pending byte store.
  task automatic cycle_negedge();
    exp_t e;
    @(negedge clk);
    cyc++;
    n_vec++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (resp_valid !== e.is_load || err_range !== e.err ||
          (e.is_load && resp_rdata !== e.rdata)) begin
        n_err++;
        $display("FAIL resp cyc %0d: got valid=%b err=%b rdata=%h, want valid=%b err=%b rdata=%h",
                 cyc, resp_valid, err_range, resp_rdata, e.is_load, e.err, e.rdata);
      end
    end else if (resp_valid !== 1'b0 || err_range !== 1'b0) begin
      n_err++;
      $display("FAIL idle_resp cyc %0d: got valid=%b err=%b, want 0 0", cyc, resp_valid, err_range);
    end
    if (rmw_pending) begin
      n_vec++;
      if (req_ready !== 1'b0 || mem_we !== 1'b1 || mem_wd !== rmw_word || mem_a !== rmw_addr) begin
        n_err++;
        $display("FAIL rmw_wr cyc %0d: got ready=%b we=%b wd=%h a=%h, want 0 1 %h %h",
                 cyc, req_ready, mem_we, mem_wd, mem_a, rmw_word, rmw_addr);
      end
      exp_mem[rmw_idx] = rmw_word;
      rmw_pending = 1'b0;
    end
  endtask

  // Present one request, hold it until accepted, record expectations, and
  // return one time step after the following posedge.
  task automatic do_req(input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] d, output int waits);
    exp_t        e;
    logic        inr;
    logic        exp_we;
    int          idx;
    int          lane;
    logic [31:0] cur;
    req_valid = 1'b1;
    req_write = w;
    req_byte  = b;
    req_addr  = a;
    req_wdata = d;
    waits     = 0;
    cycle_negedge();
    while (req_ready !== 1'b1) begin
      waits++;
      if (waits > 8) begin
        n_err++;
        $display("FAIL accept_timeout addr=%h: ready=%b, want 1", a, req_ready);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      cycle_negedge();
    end
    inr    = (a[31:2] < 30'd64);
    idx    = int'(a[7:2]);
    lane   = int'(a[1:0]);
    exp_we = w & ~b & inr;
    n_vec++;
    if (mem_we !== exp_we) begin
      n_err++;
      $display("FAIL accept_we addr=%h: got %b, want %b", a, mem_we, exp_we);
    end
    e.due = cyc + 1;
    e.is_load = ~w;
    e.err = 1'b0;
    e.rdata = '0;
    if (!inr) begin
      e.err = 1'b1;
      sb.push_back(e);
    end else if (!w) begin
      cur = exp_mem[idx];
      e.rdata = b ? {24'h0, cur[lane*8 +: 8]} : cur;
      sb.push_back(e);
    end else if (!b) begin
      exp_mem[idx] = d;
    end else begin
      cur = exp_mem[idx];
      cur[lane*8 +: 8] = d[7:0];
      rmw_pending = 1'b1;
      rmw_word = cur;
      rmw_idx = idx;
      rmw_addr = a;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    logic was_rmw;
    req_valid = 1'b0;
    was_rmw = rmw_pending;
    cycle_negedge();
    if (!was_rmw) begin
      n_vec++;
      if (mem_we !== 1'b0) begin
        n_err++;
        $display("FAIL idle_we cyc %0d: got %b, want 0", cyc, mem_we);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_waits(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: accepted after %0d stall cycles, want %0d", name, got, want);
    end
  endtask

  task automatic check_mem(input string name, input int idx, input logic [31:0] want);
    n_vec++;
    if (mem[idx] !== want) begin
      n_err++;
      $display("FAIL %s: dmem[%0d]=%h, want %h", name, idx, mem[idx], want);
    end
  endtask

  task automatic test_reset();
    // A store held on the port during reset must not be accepted or written.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0;
    req_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      cycle_negedge();
      n_vec++;
      if (req_ready !== 1'b0 || mem_we !== 1'b0 || resp_rdata !== 32'h0) begin
        n_err++;
        $display("FAIL reset_state: ready=%b we=%b rdata=%h, want 0 0 0", req_ready, mem_we, resp_rdata);
      end
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_cycle();
    check_mem("reset_no_write", 0, 32'h0);
  endtask

  task automatic test_word();
    int w;
    do_req(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, w);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, w);
    check_waits("word_ldr_wait", w, 0);
    do_req(1'b0, 1'b0, 32'h13, 32'h0, w);
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_byte_rmw();
    int w;
    do_req(1'b1, 1'b0, 32'h20, 32'h1122_3344, w);
    do_req(1'b1, 1'b1, 32'h22, 32'h0000_00AA, w);
    do_req(1'b0, 1'b0, 32'h20, 32'h0, w);
    check_waits("rmw_stall", w, 1);
    idle_cycle();
    check_mem("rmw_merge", 8, 32'h11AA_3344);
  endtask

  task automatic test_byte_loads();
    int w;
    do_req(1'b1, 1'b0, 32'h30, 32'h8899_AABB, w);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 1'b1, 32'h30 + 32'(i), 32'h0, w);
      check_waits("ldrb_b2b", w, 0);
    end
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_stall_hold();
    int w;
    do_req(1'b1, 1'b0, 32'h04, 32'h0102_0304, w);
    do_req(1'b1, 1'b1, 32'h05, 32'h0000_005A, w);
    do_req(1'b0, 1'b0, 32'h04, 32'h0, w);
    check_waits("stall_hold", w, 1);
    idle_cycle();
    check_mem("stall_merge", 1, 32'h0102_5A04);
  endtask

  task automatic test_range();
    int w;
    do_req(1'b1, 1'b0, 32'h100, 32'h1234_5678, w);
    idle_cycle();
    do_req(1'b0, 1'b0, 32'h100, 32'h0, w);
    do_req(1'b1, 1'b1, 32'h104, 32'h0000_0077, w);
    do_req(1'b0, 1'b1, 32'h3C, 32'h0, w);
    check_waits("range_no_rmw", w, 0);
    idle_cycle();
    idle_cycle();
    n_vec++;
    if (bad_write !== 1'b0) begin
      n_err++;
      $display("FAIL range_write: out-of-range dmem write seen=%b, want 0", bad_write);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int w;
    do_req(1'b1, 1'b0, 32'h08, 32'h0, w);
    do_req(1'b1, 1'b1, 32'h08, 32'h0000_00FF, w);
    // Now inside the RMW write cycle: pull reset and drop the pending store.
    rmw_pending = 1'b0;
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_vec++;
    if (mem_we !== 1'b0 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rmw_reset_we: we=%b ready=%b, want 0 0", mem_we, req_ready);
    end
    for (int i = 0; i < 2; i++) begin
      cycle_negedge();
      n_vec++;
      if (req_ready !== 1'b0 || mem_we !== 1'b0) begin
        n_err++;
        $display("FAIL rmw_reset_hold: ready=%b we=%b, want 0 0", req_ready, mem_we);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_mem("rmw_reset_mem", 2, 32'h0);
    do_req(1'b0, 1'b0, 32'h08, 32'h0, w);
    check_waits("post_reset_ready", w, 0);
    idle_cycle();
    idle_cycle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) exp_mem[i] = 32'h0;
    test_reset();
    test_word();
    test_byte_rmw();
    test_byte_loads();
    test_stall_hold();
    test_range();
    test_reset_mid_rmw();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit. It is the initiator side of the data-memory port and sits between the MEM pipeline stage and dmem.
- dmem is word-only: combinational read, synchronous word write on posedge clk.
- This block adds zero-extended byte loads (LDRB) and byte stores (STRB). Byte stores use a two-cycle read-modify-write. Word LDR/STR pass through in one cycle.
- It stalls the pipeline through req_ready and returns load data registered, one cycle after accept.

Parameters:
MEM_WORDS, 64, dmem depth in 32-bit words; word index >= MEM_WORDS raises err_range.

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset (reset=0 resets)
req_valid  input  1  MEM stage presents a load/store
req_write  input  1  1=store, 0=load
req_byte  input  1  1=byte access, 0=word access
req_addr  input  32  byte address
req_wdata  input  32  store data (byte store uses bits 7:0)
req_ready  output  1  request accepted this cycle when req_valid & req_ready
resp_valid  output  1  load data valid (one-cycle pulse)
resp_rdata  output  32  load data
err_range  output  1  one-cycle pulse, accepted access out of range
mem_a  output  32  to dmem a
mem_wd  output  32  to dmem wd
mem_we  output  1  to dmem we
mem_rd  input  32  from dmem rd (combinational)

Behaviour:
- States: IDLE, RMW_WR. Reset state IDLE.
- Reset values: resp_valid=0, resp_rdata=0, err_range=0, internal merge/address registers=0. While reset=0: req_ready=0 and mem_we=0, forced combinationally.
- req_ready = (state==IDLE) & reset deasserted.
- Address path:
  - IDLE: mem_a = req_addr.
  - RMW_WR: mem_a = latched address.
  - dmem indexes with a[31:2]. Word accesses ignore addr[1:0] (no alignment fault).
- Byte lanes are little-endian: lane = addr[1:0]; lane 0 = bits 7:0, lane 3 = bits 31:24.
- Word load (accepted in IDLE): next cycle resp_valid=1, resp_rdata = mem_rd sampled at accept.
- Byte load: next cycle resp_valid=1, resp_rdata = {24'b0, selected lane of mem_rd}.
- Word store: mem_we=1 and mem_wd=req_wdata in the accept cycle; memory updates at that posedge. No response. State stays IDLE.
- Byte store:
  - Accept cycle: mem_we=0. Latch merged word = mem_rd with the selected lane replaced by req_wdata[7:0]. Latch the address. Go to RMW_WR.
  - RMW_WR: mem_we=1, mem_wd=merged word, req_ready=0. Return to IDLE next cycle.
  - Total occupancy is 2 cycles.
- Out of range (req_addr[31:2] >= MEM_WORDS):
  - Request is still accepted.
  - err_range pulses the next cycle.
  - Stores: mem_we suppressed in every cycle. No RMW_WR entry.
  - Loads: resp_valid=1 with resp_rdata=0.
- resp_valid and err_range are deasserted in every cycle not following an accepted load or error.
- Requests presented during RMW_WR are not accepted; the requester must hold them.
- Ordering: a load accepted in the cycle right after RMW_WR observes the merged word, since the write commits at the RMW_WR posedge.
- Back-to-back word accesses are accepted every cycle. Responses are pipelined one deep with no bubble.
- Reset asserted during RMW_WR:
  - mem_we drops immediately.
  - The pending byte store is discarded; memory is unchanged by it.
  - State returns to IDLE.
- Undriven req_valid=0 in IDLE: mem_we=0, no state change.

Decomposition:
- Package dmem_lsu_pkg holds:
  - lsu_state_t enum (IDLE, RMW_WR);
  - constants WORD_BYTES=4 and LANE_W=2;
  - localparam for the 32-bit data width.
- One combinational sub-module, byte_lane_unit, does lane extract (zero-extend) and lane merge from lane, word and byte. It is shared by the load and store paths.
- FSM, response registers and the range check stay in dmem_lsu.

Test Plan:
- Word store then load: STR 0xDEADBEEF @0x10, LDR @0x10 next cycle -> mem_we pulse 1 cycle; resp_valid one cycle after the load accept with resp_rdata=0xDEADBEEF.
- Byte store RMW: word @0x20 = 0x11223344, STRB 0xAA @0x22 -> req_ready low 1 cycle; mem_we only in RMW_WR; word becomes 0x11AA3344; immediate LDR @0x20 returns 0x11AA3344.
- Byte loads all lanes: word 0x8899AABB @0x30, LDRB @0x30..0x33 back-to-back -> 0xBB, 0xAA, 0x99, 0x88, zero-extended; resp_valid continuous 4 cycles.
- Stall hold: STRB @0x04, then LDR @0x04 held valid during RMW_WR -> load accepted only in the following cycle and returns the merged word.
- Range: STR 0x12345678 @0x100 (index 64, MEM_WORDS=64) -> mem_we never asserted; err_range pulse; LDR @0x100 -> resp_rdata=0, err_range pulse.
- Reset mid-RMW: word @0x08 = 0x00000000, STRB 0xFF @0x08, reset=0 during RMW_WR -> mem_we drops same cycle; after release, word @0x08 still 0x00000000; req_ready=0 throughout reset.
